move_link: RTL and testbench

Two-player move link between `mouse_position` and the UART byte layer. The RX path decodes the opponent's byte stream into the level signals `mouse_position` consumes: `oponent_pick`, `oponent_position`, `begin_turn` and `set_player`. The TX path encodes the local `pick_place`, `mouse_position` and `next_turn` activity into the same byte protocol and sends it through a small FIFO to the UART transmitter.

---
 rtl/move_link.sv | 155 +++++++++++++++
 tb/tb_move_link.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_link.sv
// Two-player move link: decodes opponent bytes into mouse_position levels and
// encodes local pick/place, cursor and end-of-turn activity into a TX byte FIFO.
module move_link #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       local_claim,
   input  logic       pick_place,
   input  logic [5:0] mouse_position,
   input  logic       next_turn,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       oponent_pick,
   output logic [5:0] oponent_position,
   output logic       begin_turn,
   output logic       set_player,
   output logic       own_turn,
   output logic       link_err
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

   localparam logic [1:0] OP_HELLO = 2'b00;
   localparam logic [1:0] OP_PICK  = 2'b01;
   localparam logic [1:0] OP_DROP  = 2'b10;
   localparam logic [1:0] OP_END   = 2'b11;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   logic       claimed;
   logic       pending_hello, pending_state, pending_end;
   logic       pick_q;
   logic [5:0] pos_q;
   logic       next_turn_q;

   logic [1:0] rx_op;
   logic       rx_hello, rx_move, rx_end;
   logic       claim_now, changed, end_rise;
   logic       full, pop, push, push_req, drop;
   logic       wr_hello, wr_state, wr_end;
   logic [7:0] push_byte;

   assign rx_op     = rx_data[7:6];
   assign rx_hello  = rx_valid && (rx_op == OP_HELLO);
   assign rx_move   = rx_valid && ((rx_op == OP_PICK) || (rx_op == OP_DROP));
   assign rx_end    = rx_valid && (rx_op == OP_END);
   assign claim_now = local_claim && !claimed;
   assign changed   = {pick_place, mouse_position} != {pick_q, pos_q};
   assign end_rise  = own_turn && next_turn && !next_turn_q;

   assign tx_valid = (count != '0);
   assign tx_data  = tx_valid ? mem[rd_ptr] : 8'h00;
   assign full     = (count == DEPTH_CNT);
   assign pop      = tx_valid && tx_ready;

   // One byte per cycle; HELLO beats STATE beats END_TURN.
   always_comb begin
      push_req  = 1'b0;
      push_byte = 8'h00;
      wr_hello  = 1'b0;
      wr_state  = 1'b0;
      wr_end    = 1'b0;
      if (pending_hello) begin
         push_req  = 1'b1;
         push_byte = {OP_HELLO, 6'd0};
         wr_hello  = 1'b1;
      end else if (pending_state) begin
         push_req  = 1'b1;
         push_byte = {(pick_q ? OP_PICK : OP_DROP), pos_q};
         wr_state  = 1'b1;
      end else if (pending_end) begin
         push_req  = 1'b1;
         push_byte = {OP_END, 6'd0};
         wr_end    = 1'b1;
      end
   end

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push = push_req && (!full || pop);
   assign drop = push_req && !push;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         claimed          <= 1'b0;
         pending_hello    <= 1'b0;
         pending_state    <= 1'b0;
         pending_end      <= 1'b0;
         pick_q           <= 1'b0;
         pos_q            <= 6'd0;
         next_turn_q      <= 1'b0;
         oponent_pick     <= 1'b0;
         oponent_position <= 6'd0;
         begin_turn       <= 1'b0;
         set_player       <= 1'b0;
         own_turn         <= 1'b0;
         link_err         <= 1'b0;
      end else begin
         next_turn_q <= next_turn;

         // Copies always track; only our own moves are announced.
         if (changed) begin
            pick_q <= pick_place;
            pos_q  <= mouse_position;
         end

         pending_hello <= (pending_hello && !wr_hello) || claim_now;
         pending_state <= (pending_state && !wr_state) || (changed && own_turn);
         pending_end   <= (pending_end && !wr_end) || end_rise;

         if (claim_now || rx_hello) claimed <= 1'b1;
         if (claim_now) set_player <= 1'b1;

         if (claim_now || (rx_end && !own_turn)) own_turn <= 1'b1;
         else if (end_rise)                     own_turn <= 1'b0;

         if (rx_move && !own_turn) begin
            oponent_pick     <= (rx_op == OP_PICK);
            oponent_position <= rx_data[5:0];
         end else if (rx_end && !own_turn) begin
            oponent_pick <= 1'b0;
         end

         // Held through the frame_tick cycle so mouse_position is sure to see it.
         if (rx_end && !own_turn) begin_turn <= 1'b1;
         else if (frame_tick)     begin_turn <= 1'b0;

         if (drop || (rx_hello && (claimed || claim_now)) || ((rx_move || rx_end) && own_turn))
            link_err <= 1'b1;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_move_link.sv
// Directed bench for move_link: claim, opponent decode, local encode,
// backpressure/overflow, echo suppression, illegal RX and reset mid-queue.
module tb_move_link;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic       local_claim;
   logic       pick_place;
   logic [5:0] mouse_position;
   logic       next_turn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       oponent_pick;
   logic [5:0] oponent_position;
   logic       begin_turn;
   logic       set_player;
   logic       own_turn;
   logic       link_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   move_link #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .local_claim(local_claim),
      .pick_place(pick_place), .mouse_position(mouse_position), .next_turn(next_turn),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .oponent_pick(oponent_pick), .oponent_position(oponent_position),
      .begin_turn(begin_turn), .set_player(set_player), .own_turn(own_turn), .link_err(link_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Bytes leaving on the next edge, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      frame_tick = 1'b0; local_claim = 1'b0; pick_place = 1'b0;
      mouse_position = 6'd0; next_turn = 1'b0; rx_data = 8'h00;
      rx_valid = 1'b0; tx_ready = 1'b0;
      step(2);
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_tx(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      do_reset();
      rst = 1'b1;
      step(1);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_oponent", {oponent_pick, oponent_position}, 0);
      chk("rst_flags", {begin_turn, set_player, own_turn, link_err}, 0);
      rst = 1'b0;

      // local claim held 3 cycles -> one HELLO
      tx_ready = 1'b1;
      local_claim = 1'b1;
      step(3);
      local_claim = 1'b0;
      step(3);
      exp_q.push_back(8'h00);
      check_tx("claim");
      chk("claim_set_player", set_player, 1);
      chk("claim_own_turn", own_turn, 1);
      chk("claim_link_err", link_err, 0);

      // opponent claims, moves, ends turn
      do_reset();
      tx_ready = 1'b1;
      send_rx(8'h00);
      chk("opp_claim_own_turn", own_turn, 0);
      chk("opp_claim_set_player", set_player, 0);
      send_rx(8'h5B);
      chk("opp_pick", oponent_pick, 1);
      chk("opp_pos", oponent_position, 27);
      send_rx(8'hC0);
      chk("opp_end_begin_turn", begin_turn, 1);
      chk("opp_end_own_turn", own_turn, 1);
      chk("opp_end_pick", oponent_pick, 0);
      step(2);
      chk("begin_turn_held", begin_turn, 1);
      frame_tick = 1'b1;
      chk("begin_turn_tick_cycle", begin_turn, 1);
      step(1);
      frame_tick = 1'b0;
      chk("begin_turn_after_tick", begin_turn, 0);
      chk("opp_no_err", link_err, 0);

      // local move on our turn
      pick_place = 1'b1; mouse_position = 6'd12;
      step(3); exp_q.push_back(8'h4C);
      mouse_position = 6'd20;
      step(3); exp_q.push_back(8'h54);
      pick_place = 1'b0;
      step(3); exp_q.push_back(8'h94);
      next_turn = 1'b1;
      step(3); exp_q.push_back(8'hC0);
      check_tx("move");
      chk("move_own_turn", own_turn, 0);

      // backpressure: 5 changes into a 4-deep FIFO
      do_reset();
      tx_ready = 1'b1;
      local_claim = 1'b1;
      step(1);
      local_claim = 1'b0;
      step(3);
      exp_q.push_back(8'h00);
      check_tx("bp_hello");
      tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         mouse_position = 6'(i);
         step(2);
         exp_q.push_back(8'h80 | 8'(i));
      end
      chk("bp_full_no_err", link_err, 0);
      chk("bp_tx_valid", tx_valid, 1);
      mouse_position = 6'd5;
      step(2);
      chk("bp_overflow_err", link_err, 1);
      tx_ready = 1'b1;
      step(6);
      check_tx("bp_drain");

      // change + next_turn rise together -> STATE then END_TURN
      do_reset();
      tx_ready = 1'b1;
      local_claim = 1'b1;
      step(1);
      local_claim = 1'b0;
      step(3);
      pick_place = 1'b1; mouse_position = 6'd9; next_turn = 1'b1;
      step(5);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h49);
      exp_q.push_back(8'hC0);
      check_tx("simul");
      chk("simul_own_turn", own_turn, 0);

      // local claim and RX HELLO together
      do_reset();
      tx_ready = 1'b1;
      local_claim = 1'b1;
      rx_data = 8'h00; rx_valid = 1'b1;
      step(1);
      local_claim = 1'b0; rx_valid = 1'b0;
      chk("dup_link_err", link_err, 1);
      chk("dup_set_player", set_player, 1);
      chk("dup_own_turn", own_turn, 1);
      step(3);
      exp_q.push_back(8'h00);
      check_tx("dup");

      // echo suppression while opponent moves
      do_reset();
      tx_ready = 1'b1;
      send_rx(8'h00);
      pick_place = 1'b1; step(2);
      mouse_position = 6'd33; step(2);
      pick_place = 1'b0; mouse_position = 6'd7; step(3);
      chk("echo_tx_valid", tx_valid, 0);
      check_tx("echo");

      // illegal RX on our turn, then reset mid-queue
      do_reset();
      tx_ready = 1'b1;
      local_claim = 1'b1;
      step(1);
      local_claim = 1'b0;
      step(3);
      exp_q.push_back(8'h00);
      check_tx("ill_hello");
      chk("ill_pre_err", link_err, 0);
      send_rx(8'h45);
      chk("ill_link_err", link_err, 1);
      chk("ill_oponent", {oponent_pick, oponent_position}, 0);
      chk("ill_own_turn", own_turn, 1);
      tx_ready = 1'b0;
      mouse_position = 6'd7;
      step(2);
      chk("queued_tx_valid", tx_valid, 1);
      chk("queued_tx_data", tx_data, 8'h87);
      rst = 1'b1;
      step(1);
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_flags", {set_player, own_turn, link_err}, 0);
      rst = 1'b0;
      mouse_position = 6'd0;
      step(3);
      chk("postrst_tx_valid", tx_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
